sdram_wb_bridge: RTL and testbench

SDRAM_WB_BRIDGE -- requirements
Module: sdram_wb_bridge

---
 rtl/sdram_pkg.sv | 15 +
 rtl/sdram_bridge_watchdog.sv | 28 ++
 rtl/sdram_wb_bridge.sv | 155 +++++++++++++++
 tb/tb_sdram_wb_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM-controller bridge:
// FSM state encoding and the default response timeout.
package sdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } bridge_state_t;

    localparam int DEFAULT_TIMEOUT = 16384;

endpackage

// File: rtl/sdram_bridge_watchdog.sv
// Wait counter for the bridge: cleared while idle, counts while a controller
// response is outstanding, flags expiry at TIMEOUT-1.
module sdram_bridge_watchdog #(
    parameter int TIMEOUT = sdram_pkg::DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone classic slave that forwards single word accesses to an SDRAM
// controller request/ack/valid interface, with timeout and cycle-abort handling.
//
// state     | meaning
// IDLE      | waiting for wb_cyc & wb_stb
// REQ       | mem_req held until the controller accepts (mem_ack)
// RDWAIT    | read accepted, waiting for mem_valid
// RESP      | one-cycle wb_ack (suppressed if the master aborted)
// ERR       | one-cycle wb_err after a controller timeout
module sdram_wb_bridge
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [31:0]           wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_dat_w,
    input  logic [3:0]            wb_sel,
    output logic [DATA_WIDTH-1:0] wb_dat_r,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [3:0]            mem_bwe,
    input  logic                  mem_ack,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    bridge_state_t         state_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [3:0]            mem_bwe_q;
    logic [DATA_WIDTH-1:0] wb_dat_r_q;
    logic                  wb_ack_q;
    logic                  wb_err_q;
    logic                  abort_q;
    logic                  abort_d;
    logic                  busy;
    logic                  expired;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{wb_addr[31:ADDR_WIDTH+2], wb_addr[1:0]};

    // Once the master drops wb_cyc the operation still finishes, but silently.
    assign abort_d = abort_q | ~wb_cyc;
    assign busy    = (state_q == ST_REQ) || (state_q == ST_RDWAIT);

    sdram_bridge_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (~busy),
        .enable  (busy),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_bwe_q  <= '0;
            wb_dat_r_q <= '0;
            wb_ack_q   <= 1'b0;
            wb_err_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wb_ack_q <= 1'b0;
                    wb_err_q <= 1'b0;
                    if (wb_cyc && wb_stb) begin
                        mem_addr_q <= wb_addr[ADDR_WIDTH+1:2];
                        mem_data_q <= wb_dat_w;
                        mem_bwe_q  <= wb_sel;
                        mem_we_q   <= wb_we;
                        abort_q    <= 1'b0;
                        if (wb_we && (wb_sel == 4'b0000)) begin
                            state_q  <= ST_RESP;
                            wb_ack_q <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    abort_q <= abort_d;
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (mem_we_q) begin
                            state_q  <= ST_RESP;
                            wb_ack_q <= ~abort_d;
                        end else begin
                            state_q <= ST_RDWAIT;
                        end
                    end else if (expired) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_ERR;
                        wb_err_q  <= ~abort_d;
                    end
                end
                ST_RDWAIT: begin
                    abort_q <= abort_d;
                    if (mem_valid) begin
                        wb_dat_r_q <= mem_q;
                        state_q    <= ST_RESP;
                        wb_ack_q   <= ~abort_d;
                    end else if (expired) begin
                        state_q  <= ST_ERR;
                        wb_err_q <= ~abort_d;
                    end
                end
                ST_RESP: begin
                    wb_ack_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_ERR: begin
                    wb_err_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    wb_ack_q  <= 1'b0;
                    wb_err_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_bwe  = mem_bwe_q;
    assign wb_dat_r = wb_dat_r_q;
    assign wb_ack   = wb_ack_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed bench for sdram_wb_bridge with TIMEOUT=16; inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_sdram_wb_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_addr = '0, wb_dat_w = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_dat_r;
    logic        wb_ack, wb_err;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_bwe;
    logic        mem_ack = 1'b0, mem_valid = 1'b0;
    logic [31:0] mem_q = '0;

    int checks = 0;
    int errors = 0;

    sdram_wb_bridge #(
        .ADDR_WIDTH (24),
        .DATA_WIDTH (32),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_dat_w  (wb_dat_w),
        .wb_sel    (wb_sel),
        .wb_dat_r  (wb_dat_r),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_bwe   (mem_bwe),
        .mem_ack   (mem_ack),
        .mem_valid (mem_valid),
        .mem_q     (mem_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic we, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_addr = addr; wb_dat_w = dat; wb_sel = sel;
    endtask

    task automatic release_bus();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({mem_req, wb_ack, wb_err, mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got req/ack/err/we=%b required 0000",
                     {mem_req, wb_ack, wb_err, mem_we});
        end
        checks++;
        if (mem_addr !== 24'h0 || mem_data !== 32'h0 || mem_bwe !== 4'h0 || wb_dat_r !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h bwe=%h dat_r=%h required all zero",
                     mem_addr, mem_data, mem_bwe, wb_dat_r);
        end
        tick();
    endtask

    task automatic test_write();
        int ack_cnt = 0;
        int held = 0;
        start(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 24'd4 || mem_bwe !== 4'hF ||
            mem_data !== 32'hDEAD_BEEF || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_issue: got req=%b addr=%h bwe=%h data=%h we=%b required 1 000004 f deadbeef 1",
                     mem_req, mem_addr, mem_bwe, mem_data, mem_we);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_req === 1'b1 && mem_addr === 24'd4 && wb_ack === 1'b0) held++;
        end
        checks++;
        if (held !== 3) begin
            errors++;
            $display("FAIL wr_hold: got %0d stable held cycles required 3", held);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ack_cnt += int'(wb_ack);
        checks++;
        if (mem_req !== 1'b0 || wb_ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack: got req=%b ack=%b required req=0 ack=1", mem_req, wb_ack);
        end
        release_bus();
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_cnt += int'(wb_ack);
        end
        checks++;
        if (ack_cnt !== 1) begin
            errors++;
            $display("FAIL wr_ack_once: got %0d acks required 1", ack_cnt);
        end
    endtask

    task automatic test_read();
        int early = 0;
        start(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 24'd4) begin
            errors++;
            $display("FAIL rd_issue: got req=%b we=%b addr=%h required 1 0 000004", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL rd_accept: got req=%b ack=%b required 0 0", mem_req, wb_ack);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            early += int'(wb_ack);
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL rd_early_ack: got %0d acks before mem_valid required 0", early);
        end
        mem_valid = 1'b1; mem_q = 32'hCAFE_F00D;
        tick();
        mem_valid = 1'b0; mem_q = 32'h0;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_r !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rd_data: got ack=%b dat_r=%h required 1 cafef00d", wb_ack, wb_dat_r);
        end
        release_bus();
        tick();
        checks++;
        if (wb_ack !== 1'b0 || wb_dat_r !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rd_hold: got ack=%b dat_r=%h required 0 cafef00d", wb_ack, wb_dat_r);
        end
    endtask

    task automatic test_zero_sel();
        int req_seen = 0;
        int ack_cycle = 0;
        // Transaction cycle 1 presents the strobe; the ack belongs in cycle 2.
        start(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            req_seen += int'(mem_req);
            if (wb_ack === 1'b1 && ack_cycle == 0) begin
                ack_cycle = c;
                release_bus();
            end
        end
        checks++;
        if (req_seen !== 0) begin
            errors++;
            $display("FAIL zsel_req: got mem_req high %0d cycles required 0", req_seen);
        end
        checks++;
        if (ack_cycle !== 2) begin
            errors++;
            $display("FAIL zsel_ack: got ack in cycle %0d required cycle 2", ack_cycle);
        end
    endtask

    task automatic test_timeout();
        int held = 0;
        int stray = 0;
        start(1'b1, 32'h0000_0040, 32'hAAAA_5555, 4'h3);
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (mem_req === 1'b1 && wb_err === 1'b0) held++;
        end
        checks++;
        if (held !== 15) begin
            errors++;
            $display("FAIL to_hold: got %0d waiting cycles required 15", held);
        end
        tick();
        checks++;
        if (mem_req !== 1'b0 || wb_err !== 1'b1 || wb_ack !== 1'b0) begin
            errors++;
            $display("FAIL to_err: got req=%b err=%b ack=%b required 0 1 0", mem_req, wb_err, wb_ack);
        end
        release_bus();
        tick();
        checks++;
        if (wb_err !== 1'b0) begin
            errors++;
            $display("FAIL to_err_pulse: got err=%b required 0", wb_err);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stray += int'(wb_ack) + int'(wb_err) + int'(mem_req);
            tick();
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL to_stray_ack: got %0d responses required 0", stray);
        end
    endtask

    task automatic test_abort();
        int resp = 0;
        start(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        release_bus();
        tick();
        mem_valid = 1'b1; mem_q = 32'h1111_2222;
        tick();
        mem_valid = 1'b0;
        resp += int'(wb_ack) + int'(wb_err);
        tick();
        resp += int'(wb_ack) + int'(wb_err);
        checks++;
        if (resp !== 0) begin
            errors++;
            $display("FAIL abort_resp: got %0d responses required 0", resp);
        end
        start(1'b0, 32'h0000_0084, 32'h0, 4'hF);
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 24'h21) begin
            errors++;
            $display("FAIL b2b_issue: got req=%b addr=%h required 1 000021", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_valid = 1'b1; mem_q = 32'h5555_AAAA;
        tick();
        mem_valid = 1'b0;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_r !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL b2b_data: got ack=%b dat_r=%h required 1 5555aaaa", wb_ack, wb_dat_r);
        end
        release_bus();
        tick();
    endtask

    task automatic test_ack_valid_together();
        start(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        tick();
        mem_ack = 1'b1; mem_valid = 1'b1; mem_q = 32'h0000_0077;
        tick();
        mem_ack = 1'b0; mem_valid = 1'b0;
        tick();
        checks++;
        if (wb_ack !== 1'b0 || wb_dat_r !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL both_ignore_valid: got ack=%b dat_r=%h required 0 5555aaaa", wb_ack, wb_dat_r);
        end
        mem_valid = 1'b1; mem_q = 32'h0000_0099;
        tick();
        mem_valid = 1'b0;
        checks++;
        if (wb_ack !== 1'b1 || wb_dat_r !== 32'h0000_0099) begin
            errors++;
            $display("FAIL both_data: got ack=%b dat_r=%h required 1 00000099", wb_ack, wb_dat_r);
        end
        release_bus();
        tick();
    endtask

    task automatic test_reset_in_req();
        int resp = 0;
        start(1'b1, 32'h0000_0010, 32'h0000_1234, 4'h3);
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got req=%b required 1", mem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        release_bus();
        checks++;
        if ({mem_req, wb_ack, wb_err, mem_we} !== 4'b0000 || mem_addr !== 24'h0 ||
            mem_data !== 32'h0 || mem_bwe !== 4'h0 || wb_dat_r !== 32'h0) begin
            errors++;
            $display("FAIL rst_req: got req/ack/err/we=%b addr=%h data=%h bwe=%h dat_r=%h required all zero",
                     {mem_req, wb_ack, wb_err, mem_we}, mem_addr, mem_data, mem_bwe, wb_dat_r);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp += int'(wb_ack) + int'(wb_err) + int'(mem_req);
            tick();
        end
        checks++;
        if (resp !== 0) begin
            errors++;
            $display("FAIL rst_discard: got %0d responses required 0", resp);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_zero_sel();
        test_timeout();
        test_abort();
        test_ack_valid_together();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion required completion before 200000 ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule
